// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared constants, FSM state type and address field helpers for the
// direct-mapped read-only cache controller (dm_cache_controller).
//
// Word address layout (15 bits): [14:10] tag, [9:2] index, [1:0] word offset.
// A block is four 32-bit words (128 bits); word i sits at bits [32*i+31:32*i].
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W    = 15;
  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 128;
  localparam int INDEX_W   = 8;
  localparam int TAG_W     = 5;
  localparam int OFF_W     = 2;
  localparam int LINES     = 1 << INDEX_W;
  localparam int MEM_WORDS = 32000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    MISS    = 2'd2,
    RESPOND = 2'd3
  } cache_state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: INDEX_W];
  endfunction

  function automatic logic [OFF_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W-1:0];
  endfunction

  // Addresses at or above the end of main memory are answered with an error.
  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
    return addr >= ADDR_W'(MEM_WORDS);
  endfunction

  // Select one 32-bit word out of a 128-bit block.
  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] block,
                                                  input logic [OFF_W-1:0]   off);
    return block[{off, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/dm_cache_controller_if.sv
// ---------------------------------------------------------------------------
// dm_cache_controller_if
// Bundles the CPU load port and the main_memory block port of the cache.
//
// Signals:
//   cpu_req   CPU read request, held with stable cpu_addr until cpu_ready
//   cpu_addr  15-bit word address
//   cpu_ready one-cycle response strobe (cpu_data/cpu_hit/cpu_err valid)
//   cpu_data  returned word
//   cpu_hit   1 = served from cache, 0 = filled from memory
//   cpu_err   address out of range
//   mem_req   block read request to main_memory
//   mem_addr  block-aligned address
//   mem_ack   mem_data valid this cycle
//   mem_data  128-bit block
//
// Modports:
//   master  the cache controller: answers the CPU and masters the memory port
//   slave   the surrounding system: issues CPU reads and serves memory blocks
// ---------------------------------------------------------------------------
interface dm_cache_controller_if;
  import cache_pkg::*;

  logic                cpu_req;
  logic [ADDR_W-1:0]   cpu_addr;
  logic                cpu_ready;
  logic [WORD_W-1:0]   cpu_data;
  logic                cpu_hit;
  logic                cpu_err;
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [BLOCK_W-1:0]  mem_data;

  modport master (
    input  cpu_req, cpu_addr, mem_ack, mem_data,
    output cpu_ready, cpu_data, cpu_hit, cpu_err, mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, mem_ack, mem_data,
    input  cpu_ready, cpu_data, cpu_hit, cpu_err, mem_req, mem_addr
  );

endinterface

// File: rtl/cache_line_store.sv
// ---------------------------------------------------------------------------
// cache_line_store
// 256-line tag/valid/data store of the direct-mapped cache.
//   - valid bits are cleared by reset; tag and data arrays are not reset
//   - read is asynchronous by index (combinational lookup in COMPARE)
//   - a fill writes tag, data and sets valid on the clock edge
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rd_index     line to look up
//   rd_valid     valid bit of that line
//   rd_tag       stored tag of that line
//   rd_data      stored 128-bit block of that line
//   wr_en        fill strobe
//   wr_index     line to fill
//   wr_tag       tag to store
//   wr_data      block to store
// ---------------------------------------------------------------------------
module cache_line_store
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [BLOCK_W-1:0]  wr_data
);

  logic [LINES-1:0]   valid_reg;
  logic [LINES-1:0]   line_sel;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [BLOCK_W-1:0] data_mem [LINES];

  // One-hot decode of the line being filled.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_sel
      assign line_sel[gi] = wr_en && (wr_index == INDEX_W'(gi));
    end
  endgenerate

  // Lines are never invalidated except by reset (read-only cache).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_reg | line_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/dm_cache_controller.sv
// ---------------------------------------------------------------------------
// dm_cache_controller
// Direct-mapped, read-only cache between the CPU load port and main_memory.
// One read is in flight at a time: IDLE accepts, COMPARE looks up the line,
// MISS fetches the 4-word block over req/ack and fills the line, RESPOND
// pulses cpu_ready for one cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   hit_count   saturating hit counter   (only with DM_CACHE_STATS_EN)
//   miss_count  saturating fill counter  (only with DM_CACHE_STATS_EN)
//   bus         dm_cache_controller_if.master (CPU port + memory port)
//
// Optional feature macro: DM_CACHE_STATS_EN adds the hit/miss counters.
// ---------------------------------------------------------------------------
module dm_cache_controller
  import cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
`ifdef DM_CACHE_STATS_EN
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count,
`endif
  dm_cache_controller_if.master    bus
);

  cache_state_t        state_reg, state_next;
  logic [ADDR_W-1:0]   req_addr_reg, req_addr_next;
  logic                cpu_ready_reg, cpu_ready_next;
  logic [WORD_W-1:0]   cpu_data_reg, cpu_data_next;
  logic                cpu_hit_reg, cpu_hit_next;
  logic                cpu_err_reg, cpu_err_next;
  logic                mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFF_W-1:0]    req_off;

  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                fill_en;

  assign req_tag   = get_tag(req_addr_reg);
  assign req_index = get_index(req_addr_reg);
  assign req_off   = get_offset(req_addr_reg);

  // Fill only on the ack edge inside MISS; an ack in any other state is
  // ignored. A reset during MISS forces IDLE, so no fill can happen.
  assign fill_en = (state_reg == MISS) && bus.mem_ack;

  cache_line_store u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill_en),
    .wr_index (req_index),
    .wr_tag   (req_tag),
    .wr_data  (bus.mem_data)
  );

  // ---------------- state and output registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_addr_reg  <= '0;
      cpu_ready_reg <= 1'b0;
      cpu_data_reg  <= '0;
      cpu_hit_reg   <= 1'b0;
      cpu_err_reg   <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      req_addr_reg  <= req_addr_next;
      cpu_ready_reg <= cpu_ready_next;
      cpu_data_reg  <= cpu_data_next;
      cpu_hit_reg   <= cpu_hit_next;
      cpu_err_reg   <= cpu_err_next;
      mem_req_reg   <= mem_req_next;
      mem_addr_reg  <= mem_addr_next;
    end
  end

  // ---------------- next-state and output logic ----------------
  // Response outputs are loaded only on the transition into RESPOND, so they
  // hold their last value between responses. cpu_ready_next is high exactly
  // when entering RESPOND, making cpu_ready a one-cycle pulse.
  always_comb begin
    state_next     = state_reg;
    req_addr_next  = req_addr_reg;
    cpu_ready_next = 1'b0;
    cpu_data_next  = cpu_data_reg;
    cpu_hit_next   = cpu_hit_reg;
    cpu_err_next   = cpu_err_reg;
    mem_req_next   = mem_req_reg;
    mem_addr_next  = mem_addr_reg;

    case (state_reg)
      IDLE: begin
        if (bus.cpu_req) begin
          req_addr_next = bus.cpu_addr;
          state_next    = COMPARE;
        end
      end

      COMPARE: begin
        if (out_of_range(req_addr_reg)) begin
          cpu_data_next  = '0;
          cpu_hit_next   = 1'b0;
          cpu_err_next   = 1'b1;
          cpu_ready_next = 1'b1;
          state_next     = RESPOND;
        end else if (line_valid && (line_tag == req_tag)) begin
          cpu_data_next  = get_word(line_data, req_off);
          cpu_hit_next   = 1'b1;
          cpu_err_next   = 1'b0;
          cpu_ready_next = 1'b1;
          state_next     = RESPOND;
        end else begin
          // mem_req and mem_addr are registered here so both are stable
          // from the first MISS cycle until the ack edge.
          mem_req_next  = 1'b1;
          mem_addr_next = {req_addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_next    = MISS;
        end
      end

      MISS: begin
        if (bus.mem_ack) begin
          cpu_data_next  = get_word(bus.mem_data, req_off);
          cpu_hit_next   = 1'b0;
          cpu_err_next   = 1'b0;
          cpu_ready_next = 1'b1;
          mem_req_next   = 1'b0;
          state_next     = RESPOND;
        end
      end

      RESPOND: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.cpu_ready = cpu_ready_reg;
  assign bus.cpu_data  = cpu_data_reg;
  assign bus.cpu_hit   = cpu_hit_reg;
  assign bus.cpu_err   = cpu_err_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_addr  = mem_addr_reg;

`ifdef DM_CACHE_STATS_EN
  // ---------------- statistics ----------------
  // A hit is counted as the hit response is registered; a miss on its fill.
  // Error responses take neither path.
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;
  logic        count_hit;

  assign count_hit = (state_reg == COMPARE) && (state_next == RESPOND) && cpu_hit_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (count_hit && (hit_count_reg != 16'hFFFF)) begin
        hit_count_reg <= hit_count_reg + 16'd1;
      end
      if (fill_en && (miss_count_reg != 16'hFFFF)) begin
        miss_count_reg <= miss_count_reg + 16'd1;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule
